// File: rtl/gmii_tx_arbiter.sv
// Round-robin arbiter sharing one GMII transmit path between two byte-stream frame sources.
// Adds preamble/SFD, enforces the inter-frame gap, flags underrun/oversize; optional FCS via GMII_TX_ARB_FCS_EN.
module gmii_tx_arbiter #(
  parameter int IFG_CYCLES      = 12,
  parameter int PREAMBLE_LEN    = 7,
  parameter int MAX_FRAME_BYTES = 1518
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic [1:0] grant,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_abort,
  output logic [2:0] state_dbg
);

  // Source handshake: a byte moves on any rising edge where valid and ready are both high;
  // ready is only offered to the granted source, in SFD/DATA (bytes sent) and DRAIN (bytes dropped).

  localparam int BCW = $clog2(MAX_FRAME_BYTES + 1);
  localparam int PCW = $clog2(PREAMBLE_LEN + 1);
  localparam int ICW = $clog2(IFG_CYCLES + 1);

`ifdef GMII_TX_ARB_FCS_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_SFD   = 3'd2,
    ST_DATA  = 3'd3,
    ST_FCS   = 3'd4,
    ST_DRAIN = 3'd5,
    ST_IFG   = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_SFD   = 3'd2,
    ST_DATA  = 3'd3,
    ST_DRAIN = 3'd5,
    ST_IFG   = 3'd6
  } state_t;
`endif

  state_t         state;
  logic [BCW-1:0] byte_cnt;
  logic [PCW-1:0] pre_cnt;
  logic [ICW-1:0] low_cnt;
  logic           last_grant;

`ifdef GMII_TX_ARB_FCS_EN
  logic [31:0]    crc;
  logic [1:0]     fcs_cnt;
  logic [31:0]    crc_final;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign crc_final = ~crc;
`endif

  logic       accepting;
  logic       sel_valid;
  logic       sel_last;
  logic [7:0] sel_data;
  logic       arb_hit;
  logic [1:0] arb_pick;
  logic       ifg_done;

  assign accepting  = (state == ST_SFD) || (state == ST_DATA) || (state == ST_DRAIN);
  assign req0_ready = grant[0] & accepting;
  assign req1_ready = grant[1] & accepting;
  assign busy       = (state != ST_IDLE);
  assign state_dbg  = state;

  assign sel_valid = grant[1] ? req1_valid : req0_valid;
  assign sel_last  = grant[1] ? req1_last  : req0_last;
  assign sel_data  = grant[1] ? req1_data  : req0_data;

  // low_cnt holds the number of earlier consecutive tx_en-low cycles, so the gap is met
  // during the cycle that is itself the IFG_CYCLES-th low cycle.
  assign ifg_done = !gmii_tx_en && (low_cnt >= ICW'(IFG_CYCLES - 1));

  always_comb begin
    arb_hit  = enable & (req0_valid | req1_valid);
    arb_pick = 2'b10;
    if (req0_valid && req1_valid) begin
      arb_pick = last_grant ? 2'b01 : 2'b10;
    end else if (req0_valid) begin
      arb_pick = 2'b01;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      byte_cnt    <= '0;
      pre_cnt     <= '0;
      low_cnt     <= '0;
      last_grant  <= 1'b1;
      grant       <= 2'b00;
      gmii_txd    <= 8'h00;
      gmii_tx_en  <= 1'b0;
      gmii_tx_er  <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
`ifdef GMII_TX_ARB_FCS_EN
      crc         <= 32'hFFFFFFFF;
      fcs_cnt     <= 2'd0;
`endif
    end else begin
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      gmii_tx_er  <= 1'b0;

      if (gmii_tx_en) begin
        low_cnt <= '0;
      end else if (low_cnt != ICW'(IFG_CYCLES)) begin
        low_cnt <= low_cnt + ICW'(1);
      end

      case (state)
        ST_IDLE, ST_IFG: begin
          gmii_tx_en <= 1'b0;
          gmii_txd   <= 8'h00;
          if (state == ST_IFG) begin
            frame_done <= gmii_tx_en & ~gmii_tx_er;
          end
          if (arb_hit && (state == ST_IDLE || ifg_done)) begin
            grant      <= arb_pick;
            last_grant <= arb_pick[1];
            gmii_tx_en <= 1'b1;
            gmii_txd   <= 8'h55;
            pre_cnt    <= PCW'(1);
            byte_cnt   <= '0;
`ifdef GMII_TX_ARB_FCS_EN
            crc        <= 32'hFFFFFFFF;
`endif
            state      <= ST_PRE;
          end else if (state == ST_IFG && ifg_done) begin
            state <= ST_IDLE;
          end
        end

        ST_PRE: begin
          gmii_tx_en <= 1'b1;
          if (pre_cnt == PCW'(PREAMBLE_LEN)) begin
            gmii_txd <= 8'hD5;
            state    <= ST_SFD;
          end else begin
            gmii_txd <= 8'h55;
            pre_cnt  <= pre_cnt + PCW'(1);
          end
        end

        ST_SFD, ST_DATA: begin
          gmii_tx_en <= 1'b1;
          if (byte_cnt == BCW'(MAX_FRAME_BYTES) || !sel_valid) begin
            // Error byte; a last byte accepted in this same cycle ends the frame right away.
            gmii_tx_er  <= 1'b1;
            gmii_txd    <= 8'h00;
            frame_abort <= 1'b1;
            if (sel_valid && sel_last) begin
              grant <= 2'b00;
              state <= ST_IFG;
            end else begin
              state <= ST_DRAIN;
            end
          end else begin
            gmii_txd <= sel_data;
            byte_cnt <= byte_cnt + BCW'(1);
`ifdef GMII_TX_ARB_FCS_EN
            crc      <= crc32_byte(crc, sel_data);
`endif
            if (sel_last) begin
`ifdef GMII_TX_ARB_FCS_EN
              fcs_cnt <= 2'd0;
              state   <= ST_FCS;
`else
              grant   <= 2'b00;
              state   <= ST_IFG;
`endif
            end else begin
              state <= ST_DATA;
            end
          end
        end

`ifdef GMII_TX_ARB_FCS_EN
        ST_FCS: begin
          gmii_tx_en <= 1'b1;
          gmii_txd   <= crc_final[{fcs_cnt, 3'b000} +: 8];
          fcs_cnt    <= fcs_cnt + 2'd1;
          if (fcs_cnt == 2'd3) begin
            grant <= 2'b00;
            state <= ST_IFG;
          end
        end
`endif

        ST_DRAIN: begin
          gmii_tx_en <= 1'b0;
          gmii_txd   <= 8'h00;
          if (sel_valid && sel_last) begin
            grant <= 2'b00;
            state <= ST_IFG;
          end
        end

        default: begin
          gmii_tx_en <= 1'b0;
          gmii_txd   <= 8'h00;
          grant      <= 2'b00;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
